// File: rtl/ex_mem.sv
// EX/MEM pipeline register with multi-cycle HI/LO partial-product feedback.
// Optional BUBBLE-cycle counter on bubble_cnt_o when EX_MEM_BUBBLE_CNT_EN is defined.
module ex_mem #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       stall,
   input  logic [4:0]       ex_wd,
   input  logic             ex_wreg,
   input  logic [31:0]      ex_wdata,
   input  logic             ex_whilo,
   input  logic [31:0]      ex_hi,
   input  logic [31:0]      ex_lo,
   input  logic [63:0]      hilo_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic [4:0]       mem_wd,
   output logic             mem_wreg,
   output logic [31:0]      mem_wdata,
   output logic             mem_whilo,
   output logic [31:0]      mem_hi,
   output logic [31:0]      mem_lo,
   output logic [63:0]      hilo_o,
   output logic [CNT_W-1:0] cnt_o
`ifdef EX_MEM_BUBBLE_CNT_EN
   ,
   output logic [31:0]      bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {
      MODE_ADV,
      MODE_BUB,
      MODE_HOLD
   } mode_e;

   mode_e mode;

   logic [4:0]       mem_wd_q,    mem_wd_d;
   logic             mem_wreg_q,  mem_wreg_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             mem_whilo_q, mem_whilo_d;
   logic [31:0]      mem_hi_q,    mem_hi_d;
   logic [31:0]      mem_lo_q,    mem_lo_d;
   logic [63:0]      hilo_q,      hilo_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   // stall[4] without stall[3] is illegal and falls through to ADVANCE
   always_comb begin
      mode = MODE_ADV;
      if (stall[3] && stall[4]) begin
         mode = MODE_HOLD;
      end else if (stall[3]) begin
         mode = MODE_BUB;
      end
   end

   always_comb begin
      mem_wd_d    = mem_wd_q;
      mem_wreg_d  = mem_wreg_q;
      mem_wdata_d = mem_wdata_q;
      mem_whilo_d = mem_whilo_q;
      mem_hi_d    = mem_hi_q;
      mem_lo_d    = mem_lo_q;
      hilo_d      = hilo_q;
      cnt_d       = cnt_q;
      unique case (mode)
         MODE_ADV: begin
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
            mem_whilo_d = ex_whilo;
            mem_hi_d    = ex_hi;
            mem_lo_d    = ex_lo;
            hilo_d      = '0;
            cnt_d       = '0;
         end
         MODE_BUB: begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_d      = hilo_i;
            cnt_d       = cnt_i;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wd_q    <= '0;
         mem_wreg_q  <= 1'b0;
         mem_wdata_q <= '0;
         mem_whilo_q <= 1'b0;
         mem_hi_q    <= '0;
         mem_lo_q    <= '0;
         hilo_q      <= '0;
         cnt_q       <= '0;
      end else begin
         mem_wd_q    <= mem_wd_d;
         mem_wreg_q  <= mem_wreg_d;
         mem_wdata_q <= mem_wdata_d;
         mem_whilo_q <= mem_whilo_d;
         mem_hi_q    <= mem_hi_d;
         mem_lo_q    <= mem_lo_d;
         hilo_q      <= hilo_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_wd    = mem_wd_q;
   assign mem_wreg  = mem_wreg_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_whilo = mem_whilo_q;
   assign mem_hi    = mem_hi_q;
   assign mem_lo    = mem_lo_q;
   assign hilo_o    = hilo_q;
   assign cnt_o     = cnt_q;

`ifdef EX_MEM_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // saturates rather than wrapping so long stalls never read as short ones
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (mode == MODE_BUB && bubble_cnt_q != 32'hFFFF_FFFF) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: vector table plus hand sequences.
// Counter checks compile only when EX_MEM_BUBBLE_CNT_EN is defined.
module tb_ex_mem;

   typedef struct packed {
      logic [5:0]  stall;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] hilo;
      logic [1:0]  cnt;
   } in_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] hilo;
      logic [1:0]  cnt;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic [4:0]  ex_wd = '0;
   logic        ex_wreg = 1'b0;
   logic [31:0] ex_wdata = '0;
   logic        ex_whilo = 1'b0;
   logic [31:0] ex_hi = '0;
   logic [31:0] ex_lo = '0;
   logic [63:0] hilo_i = '0;
   logic [1:0]  cnt_i = '0;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_o;
`endif

   int checks = 0;
   int errors = 0;
   out_t sb[$];
   vec_t tbl[8];

   ex_mem #(.CNT_W(2)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .hilo_o(hilo_o), .cnt_o(cnt_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
      , .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic cmp_out(input string tag);
      out_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty act=0 exp=1", tag);
         return;
      end
      e = sb.pop_front();
      cmp({tag, ".wd"},    64'(mem_wd),    64'(e.wd));
      cmp({tag, ".wreg"},  64'(mem_wreg),  64'(e.wreg));
      cmp({tag, ".wdata"}, 64'(mem_wdata), 64'(e.wdata));
      cmp({tag, ".whilo"}, 64'(mem_whilo), 64'(e.whilo));
      cmp({tag, ".hi"},    64'(mem_hi),    64'(e.hi));
      cmp({tag, ".lo"},    64'(mem_lo),    64'(e.lo));
      cmp({tag, ".hilo"},  hilo_o,         e.hilo);
      cmp({tag, ".cnt"},   64'(cnt_o),     64'(e.cnt));
   endtask

   task automatic drive(input in_t v);
      stall    = v.stall;
      ex_wd    = v.wd;
      ex_wreg  = v.wreg;
      ex_wdata = v.wdata;
      ex_whilo = v.whilo;
      ex_hi    = v.hi;
      ex_lo    = v.lo;
      hilo_i   = v.hilo;
      cnt_i    = v.cnt;
   endtask

   task automatic step(input string tag, input in_t v, input out_t e);
      @(negedge clk);
      drive(v);
      sb.push_back(e);
      @(posedge clk);
      #1;
      cmp_out(tag);
   endtask

   function automatic in_t mi(logic [5:0] s, logic [4:0] wd, logic wr,
                              logic [31:0] wdat, logic wh, logic [31:0] hi,
                              logic [31:0] lo, logic [63:0] hl,
                              logic [1:0] c);
      return '{s, wd, wr, wdat, wh, hi, lo, hl, c};
   endfunction

   function automatic out_t mo(logic [4:0] wd, logic wr, logic [31:0] wdat,
                               logic wh, logic [31:0] hi, logic [31:0] lo,
                               logic [63:0] hl, logic [1:0] c);
      return '{wd, wr, wdat, wh, hi, lo, hl, c};
   endfunction

   out_t zero_o;
   out_t hold_o;

   initial begin
      zero_o = '0;
      tbl[0] = '{mi(6'b000000, 5'd3, 1, 32'h1234_5678, 0, 0, 0, 64'hDEAD, 2'd3),
                 mo(5'd3, 1, 32'h1234_5678, 0, 0, 0, 64'h0, 2'd0)};
      tbl[1] = '{mi(6'b001111, 5'd7, 1, 32'h55, 1, 32'h9, 32'h8,
                    64'h0000_0001_FFFF_FFFE, 2'd1),
                 mo(5'd0, 0, 32'h0, 0, 0, 0, 64'h0000_0001_FFFF_FFFE, 2'd1)};
      tbl[2] = '{mi(6'b011000, 5'd9, 1, 32'h77, 1, 32'h3, 32'h4, 64'h0, 2'd2),
                 mo(5'd0, 0, 32'h0, 0, 0, 0, 64'h0000_0001_FFFF_FFFE, 2'd1)};
      tbl[3] = '{mi(6'b000000, 5'd31, 0, 32'hA5A5_A5A5, 1, 32'h1, 32'h2,
                    64'h1, 2'd1),
                 mo(5'd31, 0, 32'hA5A5_A5A5, 1, 32'h1, 32'h2, 64'h0, 2'd0)};
      tbl[4] = '{mi(6'b010000, 5'd1, 1, 32'hFFFF_FFFF, 0, 32'h10, 32'h20,
                    64'h5, 2'd2),
                 mo(5'd1, 1, 32'hFFFF_FFFF, 0, 32'h10, 32'h20, 64'h0, 2'd0)};
      tbl[5] = '{mi(6'b100111, 5'd2, 1, 32'hCAFE_F00D, 1, 32'hAB, 32'hCD,
                    64'h7, 2'd3),
                 mo(5'd2, 1, 32'hCAFE_F00D, 1, 32'hAB, 32'hCD, 64'h0, 2'd0)};
      tbl[6] = '{mi(6'b101000, 5'd4, 1, 32'h1, 1, 32'h1, 32'h1,
                    64'hFFFF_FFFF_FFFF_FFFF, 2'd3),
                 mo(5'd0, 0, 32'h0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3)};
      tbl[7] = '{mi(6'b111111, 5'd6, 1, 32'h2, 1, 32'h2, 32'h2, 64'h0, 2'd0),
                 mo(5'd0, 0, 32'h0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3)};

      #2;
      sb.push_back(zero_o);
      cmp_out("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
      end

      // HOLD over three cycles with changing EX inputs
      step("hold_ld", mi(6'b0, 5'd5, 1, 32'hA5A5_A5A5, 0, 0, 0, 64'h0, 0),
           mo(5'd5, 1, 32'hA5A5_A5A5, 0, 0, 0, 64'h0, 0));
      hold_o = mo(5'd5, 1, 32'hA5A5_A5A5, 0, 0, 0, 64'h0, 0);
      for (int k = 0; k < 3; k++) begin
         step($sformatf("hold%0d", k),
              mi(6'b011111, 5'(k + 10), 0, 32'(k), 1, 32'(k), 32'(k),
                 64'(k + 100), 2'(k + 1)),
              hold_o);
      end

      // async reset between edges, mid multi-cycle
      step("pre_rst", mi(6'b0, 5'd8, 1, 32'hFFFF_FFFF, 1, 32'h3, 32'h4, 0, 0),
           mo(5'd8, 1, 32'hFFFF_FFFF, 1, 32'h3, 32'h4, 64'h0, 0));
      step("pre_rst2", mi(6'b001000, 0, 0, 0, 0, 0, 0, 64'h1234, 2'd1),
           mo(0, 0, 0, 0, 0, 0, 64'h1234, 2'd1));
      @(negedge clk);
      rst = 1'b1;
      #1;
      sb.push_back(zero_o);
      cmp_out("async_rst");
      @(posedge clk);
      #1;
      sb.push_back(zero_o);
      cmp_out("rst_held");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", mi(6'b001000, 0, 1, 32'h9, 0, 0, 0, 64'hBEEF, 2'd2),
           mo(0, 0, 0, 0, 0, 0, 64'hBEEF, 2'd2));

      // MADD: one bubble pass then the final advance
      step("madd_b", mi(6'b001000, 5'd1, 1, 32'h5, 1, 32'h7, 32'h7,
                        64'h0000_0000_0000_0003, 2'd1),
           mo(0, 0, 0, 0, 0, 0, 64'h3, 2'd1));
      step("madd_a", mi(6'b000000, 5'd0, 0, 32'h0, 1, 32'h1, 32'h2,
                        64'h3, 2'd1),
           mo(0, 0, 0, 1, 32'h1, 32'h2, 64'h0, 2'd0));

`ifdef EX_MEM_BUBBLE_CNT_EN
      @(negedge clk);
      rst = 1'b1;
      #1;
      cmp("bcnt_rst", 64'(bubble_cnt_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         stall = 6'b001000;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         stall = 6'b011000;
      end
      @(negedge clk);
      stall = 6'b000000;
      @(negedge clk);
      cmp("bcnt5", 64'(bubble_cnt_o), 64'd5);
      dut.bubble_cnt_q = 32'hFFFF_FFFF;
      stall = 6'b001000;
      @(posedge clk);
      #1;
      cmp("bcnt_sat", 64'(bubble_cnt_o), 64'hFFFF_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
